// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT). Moore strobes are registered; ir_write and the FETCH pc_write are Mealy on mem_ready.
// Each memory access waits on mem_ready for up to TIMEOUT_CYCLES cycles and halts if mem_ready never arrives. Illegal opcodes either halt or retire as a NOP.
module mc_control_unit #(
    parameter int TIMEOUT_CYCLES  = 15,
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 bne,
    output logic                 jump,
    output logic                 is_jal,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 zero_extend,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 illegal,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_write;
        logic       pc_write_cond;
        logic       bne;
        logic       jump;
        logic       is_jal;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       zero_extend;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam int              WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    function automatic logic is_ialu(input logic [5:0] op);
        return (op[5:3] == 3'b001) && (op[2:0] != 3'b111);
    endfunction

    // andi/ori/xori: 001100..001110
    function automatic logic is_zext(input logic [5:0] op);
        return (op[5:2] == 4'b0011) && (op[1:0] != 2'b11);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_J) || (op == OP_JAL) || is_ialu(op);
    endfunction

    function automatic ctrl_t moore(input state_t st, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_EXEC: begin
                if (op == OP_RTYPE) begin
                    c.alu_src_a = 1'b1;
                    c.alu_op    = 2'b10;
                end else if (op == OP_LW || op == OP_SW) begin
                    c.alu_src_a = 1'b1;
                    c.alu_src_b = 2'b10;
                end else if (op == OP_BEQ || op == OP_BNE) begin
                    c.alu_src_a     = 1'b1;
                    c.alu_op        = 2'b01;
                    c.pc_write_cond = 1'b1;
                    c.bne           = op[0];
                end else if (op == OP_J || op == OP_JAL) begin
                    c.jump      = 1'b1;
                    c.pc_write  = 1'b1;
                    c.is_jal    = (op == OP_JAL);
                    c.reg_write = (op == OP_JAL);
                end else if (is_ialu(op)) begin
                    c.alu_src_a   = 1'b1;
                    c.alu_src_b   = 2'b10;
                    c.alu_op      = 2'b11;
                    c.zero_extend = is_zext(op);
                end
            end
            S_MEM: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                c.mem_we  = (op == OP_SW);
            end
            S_WB: begin
                c.reg_write   = 1'b1;
                c.reg_dst     = (op == OP_RTYPE);
                c.mem_to_reg  = (op == OP_LW);
                c.zero_extend = is_zext(op);
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t                 state_q, state_d;
    logic [5:0]             op_q, op_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   illegal_q, illegal_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    ctrl_t                  ctrl_q;
    logic                   retire;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH) state_d = S_DECODE;
                    else                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (is_legal(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                end
            end
            S_EXEC: begin
                if (op_q == OP_RTYPE || is_ialu(op_q))  state_d = S_WB;
                else if (op_q == OP_LW || op_q == OP_SW) state_d = S_MEM;
                else                                      state_d = S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // Every entry into FETCH except the one leaving IDLE completes an instruction.
        retire  = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE);
        count_d = retire ? count_q + CNT_WIDTH'(1) : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
            ctrl_q    <= moore(state_d, op_d);
        end
    end

    logic fetch_done;
    assign fetch_done = (state_q == S_FETCH) && mem_ready;

    assign mem_req       = ctrl_q.mem_req;
    assign mem_we        = ctrl_q.mem_we;
    assign iord          = ctrl_q.iord;
    assign ir_write      = fetch_done;
    assign pc_write      = ctrl_q.pc_write | fetch_done;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign bne           = ctrl_q.bne;
    assign jump          = ctrl_q.jump;
    assign is_jal        = ctrl_q.is_jal;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign zero_extend   = ctrl_q.zero_extend;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign illegal       = illegal_q;
    assign timeout       = timeout_q;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: two instances (halting/short timeout and NOP-on-illegal/4-bit counter) against a per-instruction expected-cycle model.
`timescale 1ns/1ps
module tb_mc_control_unit;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       bne;
        logic       jump;
        logic       is_jal;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       zero_extend;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } sig_t;

    typedef struct {
        sig_t s;
        logic rdy;
        bit   opv;
        bit   ill;
        bit   to;
    } step_t;

    localparam int TO_A = 3;
    localparam int TO_B = 15;
    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BR = 3, C_J = 4, C_JAL = 5, C_IALU = 6, C_ILL = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    wire [1:0] mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, bne, jump, is_jal;
    wire [1:0] reg_write, reg_dst, mem_to_reg, zero_extend, alu_src_a, illegal, timeout;
    wire [1:0] alu_src_b [2];
    wire [1:0] alu_op [2];
    wire [31:0] cnt_a;
    wire [3:0]  cnt_b;

    int n_checks = 0;
    int n_fail = 0;
    int exp_cnt [2];
    bit exp_ill [2];
    bit exp_to [2];

    always #5 clk = ~clk;

    mc_control_unit #(.TIMEOUT_CYCLES(TO_A), .HALT_ON_ILLEGAL(1'b1), .CNT_WIDTH(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .iord(iord[0]), .ir_write(ir_write[0]),
        .pc_write(pc_write[0]), .pc_write_cond(pc_write_cond[0]), .bne(bne[0]), .jump(jump[0]),
        .is_jal(is_jal[0]), .reg_write(reg_write[0]), .reg_dst(reg_dst[0]), .mem_to_reg(mem_to_reg[0]),
        .zero_extend(zero_extend[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
        .alu_op(alu_op[0]), .illegal(illegal[0]), .timeout(timeout[0]), .instr_count(cnt_a)
    );

    mc_control_unit #(.TIMEOUT_CYCLES(TO_B), .HALT_ON_ILLEGAL(1'b0), .CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .iord(iord[1]), .ir_write(ir_write[1]),
        .pc_write(pc_write[1]), .pc_write_cond(pc_write_cond[1]), .bne(bne[1]), .jump(jump[1]),
        .is_jal(is_jal[1]), .reg_write(reg_write[1]), .reg_dst(reg_dst[1]), .mem_to_reg(mem_to_reg[1]),
        .zero_extend(zero_extend[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
        .alu_op(alu_op[1]), .illegal(illegal[1]), .timeout(timeout[1]), .instr_count(cnt_b)
    );

    function automatic sig_t obs(input int d);
        sig_t s;
        s.mem_req = mem_req[d];       s.mem_we = mem_we[d];           s.iord = iord[d];
        s.ir_write = ir_write[d];     s.pc_write = pc_write[d];       s.pc_write_cond = pc_write_cond[d];
        s.bne = bne[d];               s.jump = jump[d];               s.is_jal = is_jal[d];
        s.reg_write = reg_write[d];   s.reg_dst = reg_dst[d];         s.mem_to_reg = mem_to_reg[d];
        s.zero_extend = zero_extend[d]; s.alu_src_a = alu_src_a[d];
        s.alu_src_b = alu_src_b[d];   s.alu_op = alu_op[d];
        return s;
    endfunction

    function automatic logic [31:0] cnt_of(input int d);
        return (d == 0) ? cnt_a : {28'd0, cnt_b};
    endfunction

    function automatic int cls(input logic [5:0] op);
        int v;
        case (op)
            6'd0:        v = C_R;
            6'd35:       v = C_LW;
            6'd43:       v = C_SW;
            6'd4, 6'd5:  v = C_BR;
            6'd2:        v = C_J;
            6'd3:        v = C_JAL;
            default:     v = (op >= 6'd8 && op <= 6'd14) ? C_IALU : C_ILL;
        endcase
        return v;
    endfunction

    function automatic sig_t exp_fetch(input logic rdy);
        sig_t s = '0;
        s.mem_req = 1'b1; s.alu_src_b = 2'b01; s.ir_write = rdy; s.pc_write = rdy;
        return s;
    endfunction

    function automatic sig_t exp_decode();
        sig_t s = '0;
        s.alu_src_b = 2'b11;
        return s;
    endfunction

    function automatic sig_t exp_exec(input logic [5:0] op);
        sig_t s = '0;
        case (cls(op))
            C_R:          begin s.alu_src_a = 1; s.alu_op = 2'b10; end
            C_LW, C_SW:   begin s.alu_src_a = 1; s.alu_src_b = 2'b10; end
            C_BR:         begin s.alu_src_a = 1; s.alu_op = 2'b01; s.pc_write_cond = 1; s.bne = (op == 6'd5); end
            C_J:          begin s.jump = 1; s.pc_write = 1; end
            C_JAL:        begin s.jump = 1; s.pc_write = 1; s.is_jal = 1; s.reg_write = 1; end
            C_IALU:       begin s.alu_src_a = 1; s.alu_src_b = 2'b10; s.alu_op = 2'b11; s.zero_extend = (op >= 6'd12); end
            default:      s = '0;
        endcase
        return s;
    endfunction

    function automatic sig_t exp_mem(input logic [5:0] op);
        sig_t s = '0;
        s.mem_req = 1; s.iord = 1; s.mem_we = (cls(op) == C_SW);
        return s;
    endfunction

    function automatic sig_t exp_wb(input logic [5:0] op);
        sig_t s = '0;
        s.reg_write = 1; s.reg_dst = (cls(op) == C_R); s.mem_to_reg = (cls(op) == C_LW);
        s.zero_extend = (cls(op) == C_IALU) && (op >= 6'd12);
        return s;
    endfunction

    function automatic step_t mk(input sig_t s, input logic rdy, input bit opv, input bit ill, input bit to);
        step_t e;
        e.s = s; e.rdy = rdy; e.opv = opv; e.ill = ill; e.to = to;
        return e;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] pick_legal();
        int unsigned r = $urandom_range(0, 13);
        logic [5:0] v;
        case (r)
            0: v = 6'd0;  1: v = 6'd35; 2: v = 6'd43; 3: v = 6'd4;
            4: v = 6'd5;  5: v = 6'd2;  6: v = 6'd3;
            default: v = 6'(r + 1);
        endcase
        return v;
    endfunction

    // fw/mw: wait cycles before mem_ready in FETCH/MEM (>= timeout limit means never ready)
    task automatic run_instr(input int d, input logic [5:0] op, input int fw, input int mw, input string tag);
        step_t q[$];
        int lim;
        int c;
        bit halt, ill, to;
        logic [31:0] exp_count;
        lim  = (d == 0) ? TO_A : TO_B;
        c    = cls(op);
        ill  = exp_ill[d];
        to   = exp_to[d];
        halt = 0;
        if (fw >= lim) begin
            for (int k = 0; k < lim; k++) q.push_back(mk(exp_fetch(1'b0), 1'b0, 0, ill, to));
            halt = 1; to = 1;
        end else begin
            for (int k = 0; k < fw; k++) q.push_back(mk(exp_fetch(1'b0), 1'b0, 0, ill, to));
            q.push_back(mk(exp_fetch(1'b1), 1'b1, 0, ill, to));
        end
        if (!halt) begin
            q.push_back(mk(exp_decode(), rnd(), 1, ill, to));
            if (c == C_ILL) begin
                ill = 1;
                if (d == 0) halt = 1;
            end else begin
                q.push_back(mk(exp_exec(op), rnd(), 1, ill, to));
                if (c == C_LW || c == C_SW) begin
                    if (mw >= lim) begin
                        for (int k = 0; k < lim; k++) q.push_back(mk(exp_mem(op), 1'b0, 1, ill, to));
                        halt = 1; to = 1;
                    end else begin
                        for (int k = 0; k < mw; k++) q.push_back(mk(exp_mem(op), 1'b0, 1, ill, to));
                        q.push_back(mk(exp_mem(op), 1'b1, 1, ill, to));
                    end
                end
                if (!halt && (c == C_R || c == C_IALU || c == C_LW))
                    q.push_back(mk(exp_wb(op), rnd(), 1, ill, to));
            end
        end
        if (halt)
            for (int k = 0; k < 4; k++) q.push_back(mk('0, rnd(), 1, ill, to));
        exp_count = (d == 0) ? 32'(exp_cnt[d]) : 32'(exp_cnt[d] % 16);
        foreach (q[i]) begin
            @(posedge clk);
            #1;
            mem_ready = q[i].rdy;
            opcode    = q[i].opv ? op : 6'($urandom);
            @(negedge clk);
            n_checks++;
            if (obs(d) !== q[i].s) begin
                n_fail++;
                $display("FAIL %s step %0d strobes: actual %h required %h", tag, i, obs(d), q[i].s);
            end
            n_checks++;
            if ({illegal[d], timeout[d]} !== {q[i].ill, q[i].to}) begin
                n_fail++;
                $display("FAIL %s step %0d flags(illegal,timeout): actual %b%b required %b%b",
                         tag, i, illegal[d], timeout[d], q[i].ill, q[i].to);
            end
            n_checks++;
            if (cnt_of(d) !== exp_count) begin
                n_fail++;
                $display("FAIL %s step %0d instr_count: actual %0d required %0d", tag, i, cnt_of(d), exp_count);
            end
        end
        if (!halt) exp_cnt[d]++;
        exp_ill[d] = ill;
        exp_to[d]  = to;
    endtask

    // Asserts reset immediately, checks the asynchronous clear, then leaves one IDLE cycle.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({obs(d), illegal[d], timeout[d]} !== '0 || cnt_of(d) !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_async dut%0d: actual %h/%b%b/%0d required all zero",
                         d, obs(d), illegal[d], timeout[d], cnt_of(d));
            end
            exp_cnt[d] = 0; exp_ill[d] = 0; exp_to[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = rnd();
        opcode    = 6'($urandom);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({obs(d), illegal[d], timeout[d]} !== '0 || cnt_of(d) !== 32'd0) begin
                n_fail++;
                $display("FAIL idle dut%0d: actual %h/%b%b/%0d required all zero",
                         d, obs(d), illegal[d], timeout[d], cnt_of(d));
            end
        end
    endtask

    task automatic test_reset();
        #2;
        apply_reset();
    endtask

    task automatic test_rtype();
        run_instr(0, 6'b000000, 0, 0, "rtype");
        run_instr(0, 6'b000000, 0, 0, "rtype_again");
    endtask

    task automatic test_lw_waits();
        apply_reset();
        run_instr(0, 6'b100011, 0, 2, "lw_wait2");
        run_instr(0, 6'b101011, 1, 1, "sw_wait");
    endtask

    task automatic test_branches();
        run_instr(0, 6'b000101, 0, 0, "bne");
        run_instr(0, 6'b000100, 0, 0, "beq");
    endtask

    task automatic test_jal_ialu();
        run_instr(0, 6'b000011, 0, 0, "jal");
        run_instr(0, 6'b000010, 0, 0, "j");
        run_instr(0, 6'b001101, 0, 0, "ori");
        run_instr(0, 6'b001000, 0, 0, "addi");
    endtask

    task automatic test_illegal();
        apply_reset();
        run_instr(0, 6'b000000, 0, 0, "pre_illegal");
        run_instr(0, 6'b111111, 0, 0, "illegal_halt");
        apply_reset();
        run_instr(1, 6'b111111, 1, 0, "illegal_nop");
        run_instr(1, 6'b000000, 0, 0, "after_illegal");
    endtask

    task automatic test_timeout();
        apply_reset();
        run_instr(0, 6'b000000, TO_A, 0, "fetch_timeout");
        apply_reset();
        run_instr(0, 6'b000000, TO_A - 1, 0, "fetch_ready_at_limit");
        run_instr(0, 6'b100011, 0, TO_A - 1, "mem_ready_at_limit");
        run_instr(0, 6'b101011, 0, TO_A, "mem_timeout");
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        run_instr(0, 6'b000000, 0, 0, "mid_mem_pre");
        @(posedge clk); #1; opcode = 6'($urandom); mem_ready = 1'b1;
        @(posedge clk); #1; opcode = 6'b101011;    mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_req[0], iord[0], mem_we[0]} !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_mem request: actual %b required 111", {mem_req[0], iord[0], mem_we[0]});
        end
        #2;
        apply_reset();
    endtask

    task automatic test_random_b();
        logic [5:0] op;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pick_legal();
            run_instr(1, op, $urandom_range(0, 3), $urandom_range(0, 3), "random_b");
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int n = 0; n < 20; n++)
            run_instr(0, pick_legal(), $urandom_range(0, TO_A - 1), $urandom_range(0, TO_A - 1), "random_a");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_waits();
        test_branches();
        test_jal_ialu();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        test_random_b();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
